// File: rtl/clock_display_scan.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | Module : clock_display_scan                                            |
// | Scans six BCD time digits onto a common-anode 7-segment display with   |
// | per-frame snapshot, colon blink, set-mode flashing and hour blanking.  |
// | Rev    : 1.0                                                           |
// +------------------------------------------------------------------------+
module clock_display_scan #(
  parameter int SCAN_DIV = 50000,
  parameter int LZ_BLANK = 1
) (
  input  logic       clk,
  input  logic       cr,
  input  logic [7:0] hour,
  input  logic [7:0] minute,
  input  logic [7:0] second,
  input  logic       sec_tick,
  input  logic [5:0] blink_mask,
  output logic [5:0] an,
  output logic [6:0] seg,
  output logic       dp
);

  localparam int                 c_DIV_W   = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam logic [c_DIV_W-1:0] c_DIV_MAX = c_DIV_W'(SCAN_DIV - 1);
  localparam logic [2:0]         c_IDX_MAX = 3'd5;
  localparam logic [6:0]         c_SEG_OFF = 7'h7F;
  localparam logic [6:0]         c_SEG_DASH = 7'h3F;

  logic [c_DIV_W-1:0] r_div_cnt;
  logic [2:0]         r_idx;
  logic               r_blink_phase;
  logic               r_snap_pend;
  logic [23:0]        r_snapshot;
  logic [5:0]         r_an;
  logic [6:0]         r_seg;
  logic               r_dp;

  logic               w_div_wrap;
  logic [3:0]         w_nibble;
  logic [6:0]         w_seg_dec;
  logic               w_mask_bit;
  logic               w_blank;
  logic [5:0]         w_an;
  logic [6:0]         w_seg;
  logic               w_dp;

  assign w_div_wrap = (r_div_cnt == c_DIV_MAX);

  // Snapshot layout is {hour, minute, second}; idx 0 is the seconds units.
  always_comb begin
    w_nibble   = 4'd0;
    w_mask_bit = 1'b0;
    case (r_idx)
      3'd0: begin w_nibble = r_snapshot[3:0];   w_mask_bit = blink_mask[0]; end
      3'd1: begin w_nibble = r_snapshot[7:4];   w_mask_bit = blink_mask[1]; end
      3'd2: begin w_nibble = r_snapshot[11:8];  w_mask_bit = blink_mask[2]; end
      3'd3: begin w_nibble = r_snapshot[15:12]; w_mask_bit = blink_mask[3]; end
      3'd4: begin w_nibble = r_snapshot[19:16]; w_mask_bit = blink_mask[4]; end
      3'd5: begin w_nibble = r_snapshot[23:20]; w_mask_bit = blink_mask[5]; end
      default: begin w_nibble = 4'd0; w_mask_bit = 1'b0; end
    endcase
  end

  always_comb begin
    w_seg_dec = c_SEG_DASH;
    case (w_nibble)
      4'd0: w_seg_dec = 7'h40;
      4'd1: w_seg_dec = 7'h79;
      4'd2: w_seg_dec = 7'h24;
      4'd3: w_seg_dec = 7'h30;
      4'd4: w_seg_dec = 7'h19;
      4'd5: w_seg_dec = 7'h12;
      4'd6: w_seg_dec = 7'h02;
      4'd7: w_seg_dec = 7'h78;
      4'd8: w_seg_dec = 7'h00;
      4'd9: w_seg_dec = 7'h10;
      default: w_seg_dec = c_SEG_DASH;
    endcase
  end

  // Flashing digits go dark during the first half of each blink period.
  always_comb begin
    w_blank = 1'b0;
    if (w_mask_bit && !r_blink_phase) begin
      w_blank = 1'b1;
    end
    if ((LZ_BLANK != 0) && (r_idx == c_IDX_MAX) && (w_nibble == 4'd0)) begin
      w_blank = 1'b1;
    end
  end

  assign w_an  = ~(6'b000001 << r_idx);
  assign w_seg = w_blank ? c_SEG_OFF : w_seg_dec;
  assign w_dp  = !(((r_idx == 3'd2) || (r_idx == 3'd4)) && r_blink_phase);

  always_ff @(posedge clk) begin
    if (cr) begin
      r_div_cnt     <= '0;
      r_idx         <= 3'd0;
      r_blink_phase <= 1'b0;
      r_snap_pend   <= 1'b1;
      r_snapshot    <= 24'd0;
      r_an          <= 6'h3F;
      r_seg         <= c_SEG_OFF;
      r_dp          <= 1'b1;
    end else begin
      if (w_div_wrap) begin
        r_div_cnt <= '0;
        if (r_idx == c_IDX_MAX) begin
          r_idx       <= 3'd0;
          r_snap_pend <= 1'b1;
        end else begin
          r_idx <= r_idx + 3'd1;
        end
      end else begin
        r_div_cnt <= r_div_cnt + 1'b1;
      end

      // SCAN_DIV >= 2 keeps the capture edge apart from the frame-wrap edge.
      if (r_snap_pend) begin
        r_snapshot  <= {hour, minute, second};
        r_snap_pend <= 1'b0;
      end

      if (sec_tick) begin
        r_blink_phase <= ~r_blink_phase;
      end

      r_an  <= w_an;
      r_seg <= w_seg;
      r_dp  <= w_dp;
    end
  end

  assign an  = r_an;
  assign seg = r_seg;
  assign dp  = r_dp;

endmodule
`default_nettype wire
